imem_loader: RTL

- Writer side of the instruction-memory interface; the pipeline's IF stage is the reader.
- Receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into instruction memory.
- Holds the core in reset (cpu_rst) while a load is in progress.
- Sits beside the core top; cpu_rst is ORed with the system reset at the core.

---
 rtl/mips_loader_pkg.sv | 26 ++
 rtl/loader_word_assembler.sv | 39 +++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mips_loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
// LOADER_CHECKSUM_EN adds the CHECK state for frames with a trailing checksum byte.
package mips_loader_pkg;

    localparam logic [7:0] MAGIC_BYTE = 8'hA5;
    localparam int         LEN_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK  = 3'd6
`endif
    } loader_state_t;

    // Number of payload bytes carried by a frame of n words.
    function automatic logic [LEN_W+1:0] frame_bytes(input logic [LEN_W-1:0] n);
        return {n, 2'b00};
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Shifts incoming bytes MSB-first into a 32-bit word and emits a registered
// one-cycle word_valid strobe the cycle after the fourth byte arrives.
module loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_byte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  byte_cnt;

    // A clear only drops the partial word; a write already registered still goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift    <= '0;
                byte_cnt <= '0;
            end else if (strobe) begin
                shift    <= {shift[15:0], data_byte};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word       <= {shift, data_byte};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses A5/LEN_HI/LEN_LO/data frames and writes big-endian words.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_U = 32'(MAX_WORDS);
    localparam int                CNT_W = LEN_W + 2;

    loader_state_t    state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len_full;
    logic [CNT_W-1:0] bytes_left;
    logic             fire;
    logic             is_magic;
    logic             asm_strobe;
    logic             asm_clear;
    logic             word_valid;
    logic [31:0]      word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign fire       = in_valid && in_ready;
    assign is_magic   = (in_data == MAGIC_BYTE);
    assign len_full   = {len_hi, in_data};
    assign asm_strobe = fire && (state == S_DATA);
    assign asm_clear  = fire && (state != S_DATA);
    assign imem_we    = word_valid;
    assign imem_wdata = word;

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .data_byte  (in_data),
        .strobe     (asm_strobe),
        .clear      (asm_clear),
        .word       (word),
        .word_valid (word_valid)
    );

    // imem_addr always points at the next word slot; it advances at the end of each write cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            imem_addr    <= BASE;
            cpu_rst      <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            bytes_left   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            if (imem_we) begin
                imem_addr    <= imem_addr + ADDR_W'(4);
                words_loaded <= words_loaded + 16'd1;
            end
            case (state)
                S_IDLE, S_ERR: begin
                    if (fire && is_magic) begin
                        state        <= S_LEN_HI;
                        cpu_rst      <= 1'b1;
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        imem_addr    <= BASE;
                    end
                end
                S_LEN_HI: begin
                    if (fire) begin
                        len_hi <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        csum   <= in_data;
`endif
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (fire) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= S_CHECK;
`else
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            in_ready  <= 1'b0;
`endif
                        end else if ({{(32-LEN_W){1'b0}}, len_full} > MAX_U) begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end else begin
                            state      <= S_DATA;
                            bytes_left <= frame_bytes(len_full);
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        bytes_left <= bytes_left - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum       <= csum ^ in_data;
`endif
                        if (bytes_left == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= S_CHECK;
`else
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            in_ready  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (fire) begin
                        if (in_data == csum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    state    <= S_IDLE;
                    cpu_rst  <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
